// File: rtl/scancode_keymap_decoder.sv
`timescale 1ns/1ps
// PS/2 set-2 scan-code decoder: E0/F0 prefixes, E1 Pause skip,
// prefix timeout, per-key held levels with press/release pulses.
module scancode_keymap_decoder #(
  parameter int unsigned                NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = {NUM_KEYS{8'h00}},
  parameter logic [NUM_KEYS-1:0]        KEY_EXT        = '0,
  parameter bit                         EXT_LOOSE      = 1'b1,
  parameter int unsigned                PREFIX_TIMEOUT = 1_000_000
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [7:0]          code_in,
  input  logic                code_valid_in,
  input  logic                clear_in,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic [NUM_KEYS-1:0] press_out,
  output logic [NUM_KEYS-1:0] release_out,
  output logic                unknown_out,
  output logic                timeout_out
);

  localparam int TW =
    (PREFIX_TIMEOUT == 0) ? 1 : $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(PREFIX_TIMEOUT);
  localparam bit TO_EN = (PREFIX_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [NUM_KEYS-1:0] press_q, rel_q;
  logic                unk_q, unk_d;
  logic                to_q, to_d;

  logic [NUM_KEYS-1:0] plain_hit, ext_hit;
  logic                is_e0, is_f0, is_e1;

  assign is_e0 = (code_in == 8'hE0);
  assign is_f0 = (code_in == 8'hF0);
  assign is_e1 = (code_in == 8'hE1);

  always_comb begin
    plain_hit = '0;
    ext_hit   = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (KEY_CODES[8*i +: 8] == code_in) begin
        plain_hit[i] = !KEY_EXT[i] || EXT_LOOSE;
        ext_hit[i]   = KEY_EXT[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    unk_d   = 1'b0;
    to_d    = 1'b0;
    if (clear_in) begin
      state_d = S_IDLE;
      skip_d  = '0;
      cnt_d   = '0;
      keys_d  = '0;
    end else if (code_valid_in) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_e0: state_d = S_EXT;
            is_f0: state_d = S_BRK;
            is_e1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            default: begin
              keys_d = keys_q | plain_hit;
              unk_d  = (plain_hit == '0);
            end
          endcase
        end
        S_EXT: begin
          state_d = S_IDLE;
          unique case (1'b1)
            is_f0:         state_d = S_EXT_BRK;
            is_e0 | is_e1: state_d = S_IDLE;
            default: begin
              keys_d = keys_q | ext_hit;
              unk_d  = (ext_hit == '0);
            end
          endcase
        end
        S_BRK: begin
          state_d = S_IDLE;
          keys_d  = keys_q & ~plain_hit;
          unk_d   = (plain_hit == '0);
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          keys_d  = keys_q & ~ext_hit;
          unk_d   = (ext_hit == '0);
        end
        S_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = S_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (TO_EN && state_q != S_IDLE) begin
      // a byte landing on the limit cycle wins over the timeout
      if (cnt_q == TLIM) begin
        state_d = S_IDLE;
        skip_d  = '0;
        cnt_d   = '0;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      cnt_q   <= '0;
      keys_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      unk_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
      press_q <= keys_d & ~keys_q;
      rel_q   <= keys_q & ~keys_d;
      unk_q   <= unk_d;
      to_q    <= to_d;
    end
  end

  assign keys_out    = keys_q;
  assign press_out   = press_q;
  assign release_out = rel_q;
  assign unknown_out = unk_q;
  assign timeout_out = to_q;

endmodule

// File: tb/tb_scancode_keymap_decoder.sv
`timescale 1ns/1ps
// Table-driven scoreboard bench: main decoder (loose, timeout 16)
// plus a strict-extended instance for the non-loose alias case.
module tb_scancode_keymap_decoder;

  localparam logic [63:0] CODES =
    {8'h74, 8'h6B, 8'h72, 8'h75, 8'h23, 8'h1C, 8'h1B, 8'h1D};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] code_a = '0, code_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] keys_a, press_a, rel_a;
  logic [7:0] keys_b, press_b, rel_b;
  logic       unk_a, to_a, unk_b, to_b;

  scancode_keymap_decoder #(
    .NUM_KEYS(8), .KEY_CODES(CODES), .KEY_EXT(8'hF0),
    .EXT_LOOSE(1'b1), .PREFIX_TIMEOUT(16)
  ) dut_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .code_in(code_a), .code_valid_in(vld_a), .clear_in(clr_a),
    .keys_out(keys_a), .press_out(press_a), .release_out(rel_a),
    .unknown_out(unk_a), .timeout_out(to_a)
  );

  scancode_keymap_decoder #(
    .NUM_KEYS(8), .KEY_CODES(CODES), .KEY_EXT(8'hF0),
    .EXT_LOOSE(1'b0), .PREFIX_TIMEOUT(16)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .code_in(code_b), .code_valid_in(vld_b), .clear_in(clr_b),
    .keys_out(keys_b), .press_out(press_b), .release_out(rel_b),
    .unknown_out(unk_b), .timeout_out(to_b)
  );

  typedef struct {
    logic       u;
    logic [7:0] code;
    logic       vld;
    logic       clr;
    logic [7:0] keys;
    logic [7:0] press;
    logic [7:0] rel;
    logic       unk;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input logic u, input logic [7:0] c,
                              input logic v, input logic cl,
                              input logic [7:0] k, input logic [7:0] p,
                              input logic [7:0] r, input logic un,
                              input logic t);
    vec_t x;
    x.u = u; x.code = c; x.vld = v; x.clr = cl;
    x.keys = k; x.press = p; x.rel = r; x.unk = un; x.to = t;
    vecs.push_back(x);
  endfunction

  function automatic void mk(input logic [7:0] c, input logic [7:0] k,
                             input logic [7:0] p, input logic [7:0] r,
                             input logic un);
    add(1'b0, c, 1'b1, 1'b0, k, p, r, un, 1'b0);
  endfunction

  function automatic void idle(input logic [7:0] k, input logic t);
    add(1'b0, 8'h00, 1'b0, 1'b0, k, 8'h00, 8'h00, 1'b0, t);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    code_a = v.u ? 8'h00 : v.code;
    vld_a  = v.u ? 1'b0  : v.vld;
    clr_a  = v.u ? 1'b0  : v.clr;
    code_b = v.u ? v.code : 8'h00;
    vld_b  = v.u ? v.vld  : 1'b0;
    clr_b  = v.u ? v.clr  : 1'b0;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e.u) begin
      chk("keys", idx, keys_a, e.keys);
      chk("press", idx, press_a, e.press);
      chk("release", idx, rel_a, e.rel);
      chk("unknown", idx, {7'd0, unk_a}, {7'd0, e.unk});
      chk("timeout", idx, {7'd0, to_a}, {7'd0, e.to});
    end else begin
      chk("b_keys", idx, keys_b, e.keys);
      chk("b_press", idx, press_b, e.press);
      chk("b_release", idx, rel_b, e.rel);
      chk("b_unknown", idx, {7'd0, unk_b}, {7'd0, e.unk});
      chk("b_timeout", idx, {7'd0, to_b}, {7'd0, e.to});
    end
  endtask

  task automatic chk_zero(input int idx);
    chk("rst_keys", idx, keys_a, 8'h00);
    chk("rst_press", idx, press_a, 8'h00);
    chk("rst_release", idx, rel_a, 8'h00);
    chk("rst_unknown", idx, {7'd0, unk_a}, 8'h00);
    chk("rst_timeout", idx, {7'd0, to_a}, 8'h00);
    chk("rst_b_keys", idx, keys_b, 8'h00);
  endtask

  initial begin
    vec_t v;
    // key map: 1D=0 1B=1 1C=2 23=3 75=4 72=5 6B=6 74=7, keys 4..7 ext
    mk(8'h1D, 8'h01, 8'h01, 8'h00, 1'b0);
    idle(8'h01, 1'b0);
    mk(8'h1D, 8'h01, 8'h00, 8'h00, 1'b0);
    mk(8'hF0, 8'h01, 8'h00, 8'h00, 1'b0);
    mk(8'h1D, 8'h00, 8'h00, 8'h01, 1'b0);
    idle(8'h00, 1'b0);
    mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'h75, 8'h10, 8'h10, 8'h00, 1'b0);
    mk(8'hF0, 8'h10, 8'h00, 8'h00, 1'b0);
    mk(8'h75, 8'h00, 8'h00, 8'h10, 1'b0);
    mk(8'hF0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'h1D, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'h55, 8'h00, 8'h00, 8'h00, 1'b1);
    mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'hF0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'h75, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'hF0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b1);
    mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'hE1, 8'h00, 8'h00, 8'h00, 1'b0);
    mk(8'h1B, 8'h02, 8'h02, 8'h00, 1'b0);
    mk(8'hE0, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h1D, 8'h02, 8'h00, 8'h00, 1'b1);
    // Pause sequence is swallowed whole
    mk(8'hE1, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h14, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h77, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'hE1, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'hF0, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h14, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'hF0, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h77, 8'h02, 8'h00, 8'h00, 1'b0);
    mk(8'h1C, 8'h06, 8'h04, 8'h00, 1'b0);
    // stale E0 times out on the 17th idle cycle
    mk(8'hE0, 8'h06, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 20; i++) idle(8'h06, i == 17);
    mk(8'h1D, 8'h07, 8'h01, 8'h00, 1'b0);
    // byte on the limit cycle is still extended
    mk(8'hE0, 8'h07, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 16; i++) idle(8'h07, 1'b0);
    mk(8'h75, 8'h17, 8'h10, 8'h00, 1'b0);
    idle(8'h17, 1'b0);
    add(1'b0, 8'h23, 1'b1, 1'b1, 8'h00, 8'h00, 8'h17, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    mk(8'hF0, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    mk(8'h1D, 8'h01, 8'h01, 8'h00, 1'b0);
    mk(8'hE0, 8'h01, 8'h00, 8'h00, 1'b0);
    mk(8'h75, 8'h11, 8'h10, 8'h00, 1'b0);
    // strict instance: plain 75 is unknown
    add(1'b1, 8'h75, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    add(1'b1, 8'hE0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h75, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h75, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
    add(1'b1, 8'hE0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h75, 1'b1, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0);

    #12;
    chk_zero(-1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // async reset in the middle of a break
    v.u = 1'b0; v.code = 8'hF0; v.vld = 1'b1; v.clr = 1'b0;
    v.keys = 8'h11; v.press = 8'h00; v.rel = 8'h00;
    v.unk = 1'b0; v.to = 1'b0;
    apply(1000, v);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(1001);
    @(negedge clk);
    vld_a = 1'b0;
    rst_n = 1'b1;
    v.code = 8'h1D; v.keys = 8'h01; v.press = 8'h01;
    apply(1002, v);

    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
